// File: rtl/dummy_op_handler_pkg.sv
// -----------------------------------------------------------------------------
// dummy_op_handler_pkg
// Shared plotter-processor definitions used by the op handlers: the handler
// FSM state encoding, default widths for stepper pulse counts and positions,
// and the busy-delay counter width.
// -----------------------------------------------------------------------------
package dummy_op_handler_pkg;

  localparam int STEPPER_PULSE_NUM_X_BITS = 16;
  localparam int STEPPER_PULSE_NUM_Y_BITS = 16;
  localparam int POS_X_BITS_DEF           = 12;
  localparam int POS_Y_BITS_DEF           = 12;
  localparam int CNT_BITS                 = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } op_state_e;

  // Counter preload for a delay of 'delay' enabled cycles. Out-of-range
  // values are clamped to 1..255 so the counter can never wrap.
  function automatic logic [CNT_BITS-1:0] delay_cnt_init(input int delay);
    int d;
    d = delay;
    if (d < 1)   d = 1;
    if (d > 255) d = 255;
    return CNT_BITS'(d - 1);
  endfunction

endpackage

// File: rtl/dummy_op_handler_if.sv
// -----------------------------------------------------------------------------
// dummy_op_handler_if
// Bundles the three signal sets an op handler exposes to the processor:
//   op_*  : OpHandler_IF      (trigger in, rdy/done out)
//   mot_* : MotorsCtrl_IF     (pulse counts/trigger out, done in)
//   pos_* : PositionUpdate_IF (current position in, new position/strobe out)
// Modports:
//   slave  : the handler side
//   master : the dispatcher / test side
// -----------------------------------------------------------------------------
interface dummy_op_handler_if #(
  parameter int PULSE_NUM_X_BITS = dummy_op_handler_pkg::STEPPER_PULSE_NUM_X_BITS,
  parameter int PULSE_NUM_Y_BITS = dummy_op_handler_pkg::STEPPER_PULSE_NUM_Y_BITS,
  parameter int POS_X_BITS       = dummy_op_handler_pkg::POS_X_BITS_DEF,
  parameter int POS_Y_BITS       = dummy_op_handler_pkg::POS_Y_BITS_DEF
) ();

  logic                        op_trigger;
  logic                        op_rdy;
  logic                        op_done;

  logic [PULSE_NUM_X_BITS-1:0] mot_pulse_num_x;
  logic [PULSE_NUM_Y_BITS-1:0] mot_pulse_num_y;
  logic                        mot_trigger;
  logic                        mot_done;

  logic [POS_X_BITS-1:0]       pos_cur_x;
  logic [POS_Y_BITS-1:0]       pos_cur_y;
  logic [POS_X_BITS-1:0]       pos_new_x;
  logic [POS_Y_BITS-1:0]       pos_new_y;
  logic                        pos_update;

  modport slave (
    input  op_trigger,
    output op_rdy, op_done,
    output mot_pulse_num_x, mot_pulse_num_y, mot_trigger,
    input  mot_done,
    input  pos_cur_x, pos_cur_y,
    output pos_new_x, pos_new_y, pos_update
  );

  modport master (
    output op_trigger,
    input  op_rdy, op_done,
    input  mot_pulse_num_x, mot_pulse_num_y, mot_trigger,
    output mot_done,
    output pos_cur_x, pos_cur_y,
    input  pos_new_x, pos_new_y, pos_update
  );

endinterface

// File: rtl/dummy_op_handler.sv
// -----------------------------------------------------------------------------
// dummy_op_handler
// No-motion plotter operation handler. Accepts a trigger, requests no motion,
// stays busy for DELAY_CYCLES enabled cycles, then pulses done together with
// a position update that repeats the position sampled at trigger time.
//
// Ports:
//   clk     : system clock, rising edge
//   reset   : synchronous, active-low reset (priority over clk_en)
//   clk_en  : clock enable; all state holds while low
//   bus     : dummy_op_handler_if.slave (op_*, mot_*, pos_* signal sets)
//
// State table:
//   state | meaning
//   IDLE  | ready, a sampled trigger starts an operation
//   BUSY  | counting down the fixed delay, trigger ignored
//   DONE  | one enabled cycle of op_done + pos_update, trigger ignored
// -----------------------------------------------------------------------------
module dummy_op_handler
  import dummy_op_handler_pkg::*;
#(
  parameter int PULSE_NUM_X_BITS = STEPPER_PULSE_NUM_X_BITS,
  parameter int PULSE_NUM_Y_BITS = STEPPER_PULSE_NUM_Y_BITS,
  parameter int POS_X_BITS       = POS_X_BITS_DEF,
  parameter int POS_Y_BITS       = POS_Y_BITS_DEF,
  parameter int DELAY_CYCLES     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  dummy_op_handler_if.slave     bus
);

  localparam logic [CNT_BITS-1:0] CNT_INIT = delay_cnt_init(DELAY_CYCLES);

  op_state_e             state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [POS_X_BITS-1:0] pos_new_x_q, pos_new_x_d;
  logic [POS_Y_BITS-1:0] pos_new_y_q, pos_new_y_d;
  logic                  op_rdy_q, op_rdy_d;
  logic                  op_done_q, op_done_d;
  logic                  pos_update_q, pos_update_d;

  // Motor completion has no meaning here since motion is never requested.
  logic unused_mot_done;
  assign unused_mot_done = bus.mot_done;

  // State register, also holding the registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pos_new_x_q  <= '0;
      pos_new_y_q  <= '0;
      op_rdy_q     <= 1'b1;
      op_done_q    <= 1'b0;
      pos_update_q <= 1'b0;
    end else if (clk_en) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pos_new_x_q  <= pos_new_x_d;
      pos_new_y_q  <= pos_new_y_d;
      op_rdy_q     <= op_rdy_d;
      op_done_q    <= op_done_d;
      pos_update_q <= pos_update_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pos_new_x_d = pos_new_x_q;
    pos_new_y_d = pos_new_y_q;
    unique case (state_q)
      IDLE: begin
        if (bus.op_trigger) begin
          state_d     = BUSY;
          cnt_d       = CNT_INIT;
          pos_new_x_d = bus.pos_cur_x;
          pos_new_y_d = bus.pos_cur_y;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops aligned
  // with the state they describe.
  always_comb begin
    op_rdy_d     = (state_d == IDLE);
    op_done_d    = (state_d == DONE);
    pos_update_d = (state_d == DONE);
  end

  assign bus.op_rdy          = op_rdy_q;
  assign bus.op_done         = op_done_q;
  assign bus.pos_update      = pos_update_q;
  assign bus.pos_new_x       = pos_new_x_q;
  assign bus.pos_new_y       = pos_new_y_q;
  assign bus.mot_trigger     = 1'b0;
  assign bus.mot_pulse_num_x = {PULSE_NUM_X_BITS{1'b0}};
  assign bus.mot_pulse_num_y = {PULSE_NUM_Y_BITS{1'b0}};

endmodule

// File: tb/tb_dummy_op_handler.sv
module tb_dummy_op_handler;

  localparam int PX = 16;
  localparam int PY = 16;
  localparam int XB = 12;
  localparam int YB = 12;
  localparam int DLY = 4;

  logic clk;
  logic reset;
  logic clk_en;

  int errors = 0;
  int checks = 0;

  dummy_op_handler_if #(
    .PULSE_NUM_X_BITS(PX), .PULSE_NUM_Y_BITS(PY),
    .POS_X_BITS(XB), .POS_Y_BITS(YB)
  ) bus ();

  dummy_op_handler #(
    .PULSE_NUM_X_BITS(PX), .PULSE_NUM_Y_BITS(PY),
    .POS_X_BITS(XB), .POS_Y_BITS(YB), .DELAY_CYCLES(DLY)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst_b;
    logic          en;
    logic          trig;
    logic [XB-1:0] cx;
    logic [YB-1:0] cy;
    logic          e_rdy;
    logic          e_done;
    logic [XB-1:0] e_x;
    logic [YB-1:0] e_y;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic en, input logic tr,
                     input int cx, input int cy,
                     input logic rdy, input logic dn, input int ex, input int ey);
    vec_t v;
    v.rst_b = r; v.en = en; v.trig = tr;
    v.cx = XB'(cx); v.cy = YB'(cy);
    v.e_rdy = rdy; v.e_done = dn;
    v.e_x = XB'(ex); v.e_y = YB'(ey);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d actual=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_outputs(input int idx, input logic rdy, input logic dn,
                             input logic [XB-1:0] ex, input logic [YB-1:0] ey);
    chk("op_rdy", idx, 32'(bus.op_rdy), 32'(rdy));
    chk("op_done", idx, 32'(bus.op_done), 32'(dn));
    chk("pos_update", idx, 32'(bus.pos_update), 32'(dn));
    chk("pos_new_x", idx, 32'(bus.pos_new_x), 32'(ex));
    chk("pos_new_y", idx, 32'(bus.pos_new_y), 32'(ey));
    chk("mot_trigger", idx, 32'(bus.mot_trigger), 32'd0);
    chk("mot_pulse_x", idx, 32'(bus.mot_pulse_num_x), 32'd0);
    chk("mot_pulse_y", idx, 32'(bus.mot_pulse_num_y), 32'd0);
    chk("rdy_and_done", idx, 32'(bus.op_rdy & bus.op_done), 32'd0);
  endtask

  initial begin
    int lat;
    bit seen;

    reset          = 1'b0;
    clk_en         = 1'b0;
    bus.op_trigger = 1'b0;
    bus.mot_done   = 1'b0;
    bus.pos_cur_x  = '0;
    bus.pos_cur_y  = '0;

    // Reset, with clk_en low on the first edge to show reset priority.
    add(0, 0, 0,   0,   0, 1, 0,   0,   0);
    add(0, 1, 1,  99,  99, 1, 0,   0,   0);
    // Basic operation; position pass-through and hold.
    add(1, 1, 1, 100, 200, 0, 0, 100, 200);
    add(1, 1, 1,   7,   9, 0, 0, 100, 200);
    add(1, 1, 0,   7,   9, 0, 0, 100, 200);
    add(1, 1, 0,   7,   9, 0, 0, 100, 200);
    add(1, 1, 0,   7,   9, 0, 1, 100, 200);
    add(1, 1, 0,   7,   9, 1, 0, 100, 200);
    for (int i = 0; i < 10; i++) add(1, 1, 0, 7, 9, 1, 0, 100, 200);
    // Trigger while disabled is not sampled.
    add(1, 0, 1,   3,   4, 1, 0, 100, 200);
    // clk_en toggling every cycle doubles all latencies.
    add(1, 1, 1,   5,   6, 0, 0,   5,   6);
    add(1, 0, 0,   8,   8, 0, 0,   5,   6);
    add(1, 1, 0,   8,   8, 0, 0,   5,   6);
    add(1, 0, 0,   8,   8, 0, 0,   5,   6);
    add(1, 1, 0,   8,   8, 0, 0,   5,   6);
    add(1, 0, 0,   8,   8, 0, 0,   5,   6);
    add(1, 1, 0,   8,   8, 0, 0,   5,   6);
    add(1, 0, 0,   8,   8, 0, 0,   5,   6);
    add(1, 1, 0,   8,   8, 0, 1,   5,   6);
    add(1, 0, 1,   8,   8, 0, 1,   5,   6);
    add(1, 1, 0,   8,   8, 1, 0,   5,   6);
    add(1, 0, 0,   8,   8, 1, 0,   5,   6);
    // Trigger held high: back-to-back ops, done every DLY+2 cycles.
    add(1, 1, 1,  11,  22, 0, 0,  11,  22);
    add(1, 1, 1,  33,  44, 0, 0,  11,  22);
    add(1, 1, 1,  33,  44, 0, 0,  11,  22);
    add(1, 1, 1,  33,  44, 0, 0,  11,  22);
    add(1, 1, 1,  33,  44, 0, 1,  11,  22);
    add(1, 1, 1,  33,  44, 1, 0,  11,  22);
    add(1, 1, 1,  33,  44, 0, 0,  33,  44);
    add(1, 1, 1,  55,  66, 0, 0,  33,  44);
    add(1, 1, 1,  55,  66, 0, 0,  33,  44);
    add(1, 1, 1,  55,  66, 0, 0,  33,  44);
    add(1, 1, 1,  55,  66, 0, 1,  33,  44);
    add(1, 1, 1,  55,  66, 1, 0,  33,  44);
    add(1, 1, 0,  55,  66, 1, 0,  33,  44);
    // Reset two cycles into BUSY aborts without a done pulse.
    add(1, 1, 1,  50,  60, 0, 0,  50,  60);
    add(1, 1, 0,  50,  60, 0, 0,  50,  60);
    add(1, 1, 0,  50,  60, 0, 0,  50,  60);
    add(0, 1, 0,  50,  60, 1, 0,   0,   0);
    add(0, 1, 0,  50,  60, 1, 0,   0,   0);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 50, 60, 1, 0, 0, 0);
    // A following trigger completes normally.
    add(1, 1, 1,  70,  80, 0, 0,  70,  80);
    add(1, 1, 0,  70,  80, 0, 0,  70,  80);
    add(1, 1, 0,  70,  80, 0, 0,  70,  80);
    add(1, 1, 0,  70,  80, 0, 0,  70,  80);
    add(1, 1, 0,  70,  80, 0, 1,  70,  80);
    add(1, 1, 0,  70,  80, 1, 0,  70,  80);
    add(1, 1, 0,  70,  80, 1, 0,  70,  80);

    foreach (vecs[i]) begin
      reset          = vecs[i].rst_b;
      clk_en         = vecs[i].en;
      bus.op_trigger = vecs[i].trig;
      bus.pos_cur_x  = vecs[i].cx;
      bus.pos_cur_y  = vecs[i].cy;
      bus.mot_done   = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      chk_outputs(i, vecs[i].e_rdy, vecs[i].e_done, vecs[i].e_x, vecs[i].e_y);
    end

    // Latency measured with a bounded wait: single-cycle trigger.
    reset          = 1'b1;
    clk_en         = 1'b1;
    bus.op_trigger = 1'b1;
    bus.pos_cur_x  = 12'd123;
    bus.pos_cur_y  = 12'd456;
    @(posedge clk);
    @(negedge clk);
    bus.op_trigger = 1'b0;
    bus.pos_cur_x  = 12'd1;
    bus.pos_cur_y  = 12'd2;
    chk("lat_rdy_fall", 1000, 32'(bus.op_rdy), 32'd0);
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      bus.mot_done = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (bus.op_done) seen = 1'b1;
    end
    chk("lat_done_seen", 1001, 32'(seen), 32'd1);
    chk("lat_cycles", 1002, 32'(lat), 32'(DLY));
    chk_outputs(1003, 1'b0, 1'b1, 12'd123, 12'd456);
    @(posedge clk);
    @(negedge clk);
    chk_outputs(1004, 1'b1, 1'b0, 12'd123, 12'd456);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
